// File: rtl/cfg_counter_pkg.sv
// Shared types for the configurable counter: count modes, one-shot FSM states
// and the decoding of the raw 2-bit mode input.
package cfg_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encoding 3 is reserved and treated as a plain wrapping counter.
    localparam mode_e MODE_FALLBACK = MODE_WRAP;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        return (raw == 2'd3) ? MODE_FALLBACK : mode_e'(raw);
    endfunction

endpackage

// File: rtl/cfg_counter_step.sv
// Combinational single-step datapath: next count value plus terminal-value,
// wrap and saturate indications for the current direction and mode.
module cfg_counter_step
    import cfg_counter_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = longint'(1) << WIDTH
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             dir,
    input  mode_e            mode,
    output logic [WIDTH-1:0] nxt,
    output logic             at_tv,
    output logic             wrap_evt,
    output logic             sat_evt
);

    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_w;
    logic [WIDTH:0] tv;
    logic [WIDTH:0] sum;

    // One extra bit so the modulus compare never depends on natural rollover.
    assign cnt_w = {1'b0, cnt};
    assign tv    = dir ? MAX_V : '0;
    assign at_tv = (cnt_w == tv);
    assign sum   = dir ? cnt_w + ONE : cnt_w - ONE;

    always_comb begin
        nxt      = sum[WIDTH-1:0];
        wrap_evt = 1'b0;
        sat_evt  = 1'b0;
        if (at_tv) begin
            case (mode)
                MODE_SAT: begin
                    nxt     = cnt;
                    sat_evt = 1'b1;
                end
                MODE_ONESHOT: nxt = cnt;
                default: begin
                    nxt      = dir ? '0 : MAX_V[WIDTH-1:0];
                    wrap_evt = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/cfg_counter.sv
// Parametrised up/down counter with wrap/saturate/one-shot modes, sync
// clear/load, terminal-count pulse, sticky overflow and a snapshot register.
module cfg_counter
    import cfg_counter_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = longint'(1) << WIDTH,
    parameter longint RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             snap,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] nxt_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] snap_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    mode_e            md;
    state_e           state, state_d;
    logic [WIDTH-1:0] step_nxt, cnt_d, ld_val, tv_val;
    logic             at_tv, wrap_evt, sat_evt, oneshot_end;
    logic             step, tc_d, ovf_d, sat_hold, sat_hold_d;

    assign md = decode_mode(mode);

    cfg_counter_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
        .cnt      (cnt_o),
        .dir      (dir),
        .mode     (md),
        .nxt      (step_nxt),
        .at_tv    (at_tv),
        .wrap_evt (wrap_evt),
        .sat_evt  (sat_evt)
    );

    assign ld_val = ({1'b0, load_val} > {1'b0, MAX_V}) ? MAX_V : load_val;
    assign tv_val = dir ? MAX_V : '0;
    // A one-shot run ends on the step that lands on TV (or starts already there).
    assign oneshot_end = at_tv || (step_nxt == tv_val);

    always_comb begin
        cnt_d      = cnt_o;
        state_d    = state;
        tc_d       = 1'b0;
        ovf_d      = ovf_o;
        sat_hold_d = sat_hold;
        step       = 1'b0;
        if (clr) begin
            cnt_d      = RST_V;
            state_d    = ST_IDLE;
            ovf_d      = 1'b0;
            sat_hold_d = 1'b0;
        end else if (load) begin
            cnt_d      = ld_val;
            state_d    = ST_IDLE;
            sat_hold_d = 1'b0;
        end else begin
            if (md != MODE_ONESHOT)
                state_d = ST_IDLE;
            step = en && !(md == MODE_ONESHOT && state == ST_DONE);
            if (step) begin
                cnt_d = step_nxt;
                // sat_hold marks "already pulsed for this saturation".
                sat_hold_d = sat_evt;
                if (wrap_evt || sat_evt)
                    ovf_d = 1'b1;
                if (wrap_evt || (sat_evt && !sat_hold))
                    tc_d = 1'b1;
                if (md == MODE_ONESHOT) begin
                    if (oneshot_end) begin
                        state_d = ST_DONE;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
        end
    end

    assign nxt_o  = cnt_d;
    assign busy_o = (state == ST_RUN);
    assign done_o = (state == ST_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_o    <= RST_V;
            tc_o     <= 1'b0;
            ovf_o    <= 1'b0;
            snap_o   <= '0;
            state    <= ST_IDLE;
            sat_hold <= 1'b0;
        end else begin
            cnt_o    <= cnt_d;
            tc_o     <= tc_d;
            ovf_o    <= ovf_d;
            state    <= state_d;
            sat_hold <= sat_hold_d;
            if (snap)
                snap_o <= cnt_o;
        end
    end

endmodule

// File: tb/tb_cfg_counter.sv
// Two counters (WIDTH=4/MODULUS=10 and WIDTH=3/default modulus) share stimulus
// and are compared every cycle against a behavioural model of the counter rules.
module tb_cfg_counter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0, snap = 1'b0;
    logic [3:0] lv = '0;
    logic [1:0] mode = '0;

    logic [3:0] cnt_a, nxt_a, snap_a;
    logic [2:0] cnt_b, nxt_b, snap_b;
    logic       tc_a, ovf_a, busy_a, done_a;
    logic       tc_b, ovf_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cfg_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_a (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load), .load_val(lv),
        .dir(dir), .mode(mode), .snap(snap), .cnt_o(cnt_a), .nxt_o(nxt_a),
        .tc_o(tc_a), .ovf_o(ovf_a), .snap_o(snap_a), .busy_o(busy_a), .done_o(done_a)
    );

    cfg_counter #(.WIDTH(3)) u_b (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load), .load_val(lv[2:0]),
        .dir(dir), .mode(mode), .snap(snap), .cnt_o(cnt_b), .nxt_o(nxt_b),
        .tc_o(tc_b), .ovf_o(ovf_b), .snap_o(snap_b), .busy_o(busy_b), .done_o(done_b)
    );

    // Model state per counter; st: 0 idle, 1 running, 2 done.
    int MOD[2] = '{10, 8};
    int mc[2], mo[2], mt[2], ms[2], mst[2], mh[2];
    int nc[2], no[2], nt[2], ns[2], nst[2], nh[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mo[i] = 0; mt[i] = 0; ms[i] = 0; mst[i] = 0; mh[i] = 0;
        end
    endtask

    // Next model state from the current inputs.
    task automatic calc(input int i);
        int md, tv, c, lvv;
        md  = (mode == 2'd3) ? 0 : int'(mode);
        c   = mc[i];
        lvv = (i == 0) ? int'(lv) : int'(lv[2:0]);
        tv  = dir ? MOD[i] - 1 : 0;
        nc[i] = c; no[i] = mo[i]; nt[i] = 0; nst[i] = mst[i]; nh[i] = mh[i];
        ns[i] = snap ? c : ms[i];
        if (clr) begin
            nc[i] = 0; no[i] = 0; nst[i] = 0; nh[i] = 0;
        end else if (load) begin
            nc[i] = (lvv > MOD[i] - 1) ? MOD[i] - 1 : lvv;
            nst[i] = 0; nh[i] = 0;
        end else begin
            if (md != 2) nst[i] = 0;
            if (en && !(md == 2 && mst[i] == 2)) begin
                nh[i] = (md == 1 && c == tv) ? 1 : 0;
                if (c != tv) nc[i] = dir ? c + 1 : c - 1;
                else if (md == 0) begin
                    nc[i] = dir ? 0 : MOD[i] - 1; nt[i] = 1; no[i] = 1;
                end else if (md == 1) begin
                    nt[i] = (mh[i] == 0) ? 1 : 0; no[i] = 1;
                end
                if (md == 2) begin
                    if (nc[i] == tv) begin nst[i] = 2; nt[i] = 1; end
                    else nst[i] = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic l, input logic [3:0] v,
                         input logic d, input logic [1:0] m, input logic s);
        en = e; clr = c; load = l; lv = v; dir = d; mode = m; snap = s;
    endtask

    task automatic tick();
        calc(0); calc(1);
        #1;
        check("nxt_a", 32'(nxt_a), nc[0]);
        check("nxt_b", 32'(nxt_b), nc[1]);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            mc[i] = nc[i]; mo[i] = no[i]; mt[i] = nt[i]; ms[i] = ns[i]; mst[i] = nst[i]; mh[i] = nh[i];
        end
        check("cnt_a",  32'(cnt_a),  mc[0]);
        check("tc_a",   32'(tc_a),   mt[0]);
        check("ovf_a",  32'(ovf_a),  mo[0]);
        check("snap_a", 32'(snap_a), ms[0]);
        check("busy_a", 32'(busy_a), 32'(mst[0] == 1));
        check("done_a", 32'(done_a), 32'(mst[0] == 2));
        check("cnt_b",  32'(cnt_b),  mc[1]);
        check("tc_b",   32'(tc_b),   mt[1]);
        check("ovf_b",  32'(ovf_b),  mo[1]);
        check("snap_b", 32'(snap_b), ms[1]);
        check("busy_b", 32'(busy_b), 32'(mst[1] == 1));
        check("done_b", 32'(done_b), 32'(mst[1] == 2));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cnt"},  32'({cnt_a, 1'b0, cnt_b}), 0);
        check({tag, "_snap"}, 32'({snap_a, 1'b0, snap_b}), 0);
        check({tag, "_flags"}, 32'({tc_a, ovf_a, busy_a, done_a, tc_b, ovf_b, busy_b, done_b}), 0);
    endtask

    initial begin
        mreset();
        #12;
        check_reset("rst");
        @(negedge clk) rstn = 1'b1;

        // wrap up then wrap down (u_b down crosses 0 -> 7)
        repeat (12) begin drive(1, 0, 0, 0, 1, 0, 0); tick(); end
        drive(0, 1, 0, 0, 1, 0, 0); tick();
        repeat (10) begin drive(1, 0, 0, 0, 0, 0, 0); tick(); end

        // saturate at top, then clear
        drive(0, 0, 1, 4'd9, 1, 1, 0); tick();
        repeat (4) begin drive(1, 0, 0, 0, 1, 1, 0); tick(); end
        drive(0, 1, 0, 0, 1, 1, 0); tick();
        repeat (12) begin drive(1, 0, 0, 0, 1, 1, 0); tick(); end

        // one-shot run to done, held, reload, restart
        drive(0, 1, 0, 0, 1, 2, 0); tick();
        repeat (16) begin drive(1, 0, 0, 0, 1, 2, 0); tick(); end
        drive(0, 0, 1, 4'd2, 1, 2, 0); tick();
        repeat (4) begin drive(1, 0, 0, 0, 1, 2, 0); tick(); end

        // priority clr > load > en with snapshot, then clamped load
        drive(0, 0, 1, 4'd4, 1, 0, 0); tick();
        drive(1, 1, 1, 4'd7, 1, 0, 1); tick();
        check("prio_snap_a", 32'(snap_a), 4);
        drive(0, 0, 1, 4'd12, 1, 0, 0); tick();
        check("clamp_a", 32'(cnt_a), 9);

        // reserved mode behaves as wrap
        repeat (12) begin drive(1, 0, 0, 0, 1, 3, 0); tick(); end

        // async reset during a one-shot run, no clock edge involved
        drive(0, 1, 0, 0, 1, 2, 0); tick();
        repeat (3) begin drive(1, 0, 0, 0, 1, 2, 1); tick(); end
        rstn = 1'b0;
        #2;
        check_reset("async");
        mreset();
        @(negedge clk) rstn = 1'b1;
        drive(1, 0, 0, 0, 1, 0, 0); tick();
        check("post_rst_cnt_a", 32'(cnt_a), 1);

        // randomized traffic
        repeat (1500) begin
            en   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 19) == 0);
            lv   = 4'($urandom_range(0, 15));
            snap = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_counter.md
Name: cfg_counter

Overview:
- Parametrised up/down counter; next generation of the team's 3-bit free-running counter.
- Adds generic width, programmable modulus, and three count modes: wrap, saturate, one-shot.
- Adds synchronous clear/load, terminal-count pulse, sticky overflow flag and a snapshot register, so benches observe state through ports instead of forcing internal nets.
- Used as the reusable timer/event-counter primitive in the simulation designs.

Parameters:
- WIDTH, 8: counter width in bits, legal range 2..32.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1. Legal range 2..2**WIDTH.
- RST_VAL, 0: cnt_o value on reset and on clr. Must be < MODULUS.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  count enable; one step per cycle while high.
- clr  in  1  synchronous clear to RST_VAL.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value; values >= MODULUS are clamped to MODULUS-1.
- dir  in  1  1 = count up, 0 = count down.
- mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
- snap  in  1  capture cnt_o into snap_o.
- cnt_o  out  WIDTH  registered count.
- nxt_o  out  WIDTH  combinational next value (observability only).
- tc_o  out  1  registered one-cycle pulse on a terminal-count event.
- ovf_o  out  1  sticky flag: set on wrap or saturate event.
- snap_o  out  WIDTH  registered snapshot value.
- busy_o  out  1  ONESHOT run in progress.
- done_o  out  1  ONESHOT finished; level signal.

Behaviour:
- Reset (rstn low, asynchronous):
  - cnt_o = RST_VAL, snap_o = 0.
  - tc_o, ovf_o, busy_o, done_o = 0.
  - FSM state = IDLE.
- Priority each cycle: clr > load > en.
- clr:
  - cnt_o <= RST_VAL; ovf_o <= 0; FSM -> IDLE.
  - tc_o is 0 that cycle.
- load:
  - cnt_o <= clamped load_val.
  - ONESHOT FSM -> IDLE. ovf_o is unchanged.
- Terminal value TV = MODULUS-1 when dir=1, 0 when dir=0.
- en with cnt != TV: cnt +/- 1.
- en with cnt == TV:
  - WRAP: cnt goes to 0 (up) or MODULUS-1 (down). tc_o pulses next cycle. ovf_o <= 1.
  - SAT: cnt holds. tc_o pulses only on the first cycle of reaching TV, not while holding. ovf_o <= 1 on each attempted step past TV.
  - ONESHOT: see FSM.
- en low: cnt holds; tc_o = 0.
- Arithmetic is computed WIDTH+1 wide. Modulus compare is explicit, never relies on natural rollover unless MODULUS = 2**WIDTH.
- nxt_o = value cnt_o will take at the next edge given the current inputs; purely combinational.
- ONESHOT FSM:
  - IDLE: en=1 -> RUN. Counting starts in that same cycle. busy_o = 1 from the next cycle.
  - RUN: counts while en=1. When cnt reaches TV: -> DONE, tc_o pulses, cnt holds.
  - DONE: done_o = 1, busy_o = 0. en is ignored. Leaves only via clr or load (-> IDLE).
  - In modes other than ONESHOT the FSM stays in IDLE.
- Mode change mid-count: takes effect on the next step. If the FSM is in RUN or DONE and mode leaves ONESHOT, FSM -> IDLE.
- dir change mid-count: the next step uses the new direction. No tc_o unless a TV is hit.
- snap:
  - snap_o <= cnt_o (pre-update value) on the same edge.
  - Independent of clr, load and en.
  - snap together with clr captures the old count.
- Reset asserted mid-operation: all outputs return to reset values immediately, without waiting for a clock edge.
- Latency: cnt_o, tc_o, ovf_o, snap_o, busy_o and done_o are all 1 cycle from the input edge.

Decomposition:
- Package cfg_counter_pkg:
  - mode enum: WRAP, SAT, ONESHOT.
  - FSM state enum: IDLE, RUN, DONE.
  - helper constant for the mode-3 fallback.
- Sub-module cfg_counter_step (combinational):
  - Inputs: cnt, dir, mode, MODULUS.
  - Outputs: next value, at_tv, wrap_evt, sat_evt.
  - Top level holds the registers, FSM and priority logic.

Test Plan:
- WRAP up: WIDTH=3, MODULUS=6, en=1, dir=1 for 8 cycles after reset -> cnt 0,1,2,3,4,5,0,1. tc_o pulses once, the cycle after 5->0. ovf_o=1 from then on.
- WRAP down, default MODULUS: WIDTH=3, dir=0 from 0 -> 7,6,... tc_o pulse and ovf_o set at the 0->7 step.
- SAT up: load 5 (MODULUS=6), en for 4 cycles -> cnt stays 5. tc_o pulses exactly once. ovf_o=1. Then clr -> cnt 0, ovf_o 0.
- ONESHOT: WIDTH=4, MODULUS=10, en held high -> busy_o high. cnt reaches 9, then done_o=1 and busy_o=0. cnt stays 9 for 5 more en cycles. load 2 -> IDLE; en restarts the run.
- Priority/snapshot: assert clr, load=1 (load_val=7), en and snap together with cnt=4 -> cnt_o=RST_VAL, snap_o=4, tc_o=0. load_val=12 with MODULUS=10 -> cnt_o=9.
- Async reset: drop rstn mid-edge-free interval during a ONESHOT RUN -> all outputs reset with no clock edge. Release; first en step gives cnt=1.
